// File: rtl/mmio_router_pkg.sv
// Shared types and default address map for the MMIO bus router.
package mmio_router_pkg;
  localparam int WIN_W  = 12;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;  // up to 8 windows

  localparam logic [19:0]        DEF_MMIO_UPPER = 20'haaaaa;
  localparam logic [4*WIN_W-1:0] DEF_WIN_BASE   = {12'h700, 12'h600, 12'h500, 12'h400};
  localparam logic [4*WIN_W-1:0] DEF_WIN_SIZE   = {12'h008, 12'h020, 12'h002, 12'h008};

  typedef enum logic [1:0] {SRC_MEM, SRC_PERIPH, SRC_ZERO} src_e;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
endpackage

// File: rtl/mmio_window_decode.sv
// Address decode: MMIO page match, per-window hit vector, lowest-index winner and its relative offset.
module mmio_window_decode
  import mmio_router_pkg::*;
#(
  parameter int                            NUM_PERIPH = 4,
  parameter logic [19:0]                   MMIO_UPPER = DEF_MMIO_UPPER,
  parameter logic [NUM_PERIPH*WIN_W-1:0]   WIN_BASE   = DEF_WIN_BASE,
  parameter logic [NUM_PERIPH*WIN_W-1:0]   WIN_SIZE   = DEF_WIN_SIZE
) (
  input  logic [DATA_W-1:0]     addr,
  output logic                  mmio,
  output logic [NUM_PERIPH-1:0] hit,
  output logic [IDX_W-1:0]      idx,
  output logic [WIN_W-1:0]      rel_off
);
  logic [WIN_W-1:0] off;

  assign mmio = (addr[31:12] == MMIO_UPPER);
  assign off  = addr[WIN_W-1:0];

  // 13-bit bounds so a window ending at the top of the page does not wrap
  for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_win
    localparam logic [WIN_W:0] LO = {1'b0, WIN_BASE[i*WIN_W +: WIN_W]};
    localparam logic [WIN_W:0] HI = LO + {1'b0, WIN_SIZE[i*WIN_W +: WIN_W]};
    assign hit[i] = mmio && ({1'b0, off} >= LO) && ({1'b0, off} < HI);
  end

  always_comb begin
    idx     = '0;
    rel_off = '0;
    for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx     = IDX_W'(i);
        rel_off = off - WIN_BASE[i*WIN_W +: WIN_W];
      end
    end
  end
endmodule

// File: rtl/mmio_bus_router.sv
// Routes CPU data accesses to block memory or MMIO windows (req/ack with timeout);
// an aux master gets the memory port on idle cycles with starvation-forced slots.
module mmio_bus_router
  import mmio_router_pkg::*;
#(
  parameter int                          NUM_PERIPH = 4,
  parameter logic [19:0]                 MMIO_UPPER = DEF_MMIO_UPPER,
  parameter logic [NUM_PERIPH*WIN_W-1:0] WIN_BASE   = DEF_WIN_BASE,
  parameter logic [NUM_PERIPH*WIN_W-1:0] WIN_SIZE   = DEF_WIN_SIZE,
  parameter logic [31:0]                 MEM_OFFSET = 32'h2000,
  parameter int                          TIMEOUT    = 16,
  parameter int                          STARVE_LIM = 8
) (
  input  logic                         clk,
  input  logic                         Rst,
  input  logic [DATA_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_din,
  input  logic                         cpu_wea,
  input  logic                         cpu_rea,
  input  logic [3:0]                   cpu_en,
  input  logic [2:0]                   cpu_storecntrl,
  output logic [DATA_W-1:0]            cpu_dout,
  output logic                         cpu_hold,
  output logic [NUM_PERIPH-1:0]        p_req,
  output logic                         p_wr,
  output logic [WIN_W-1:0]             p_addr,
  output logic [DATA_W-1:0]            p_din,
  input  logic [NUM_PERIPH-1:0]        p_ack,
  input  logic [NUM_PERIPH*DATA_W-1:0] p_dout,
  input  logic                         aux_req,
  input  logic                         aux_wr,
  input  logic [DATA_W-1:0]            aux_addr,
  input  logic [DATA_W-1:0]            aux_din,
  output logic                         aux_gnt,
  output logic [DATA_W-1:0]            aux_dout,
  output logic                         mem_req,
  output logic                         mem_wr,
  output logic [3:0]                   mem_wen,
  output logic [2:0]                   mem_strctrl,
  output logic [DATA_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_din,
  input  logic [DATA_W-1:0]            mem_dout,
  output logic                         bus_err,
  input  logic                         err_clr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  state_e state, state_nxt;
  src_e   src_q;
  logic                  mmio, any_hit;
  logic [NUM_PERIPH-1:0] hit;
  logic [IDX_W-1:0]      idx, ch_q;
  logic [WIN_W-1:0]      rel_off;
  logic [TW-1:0]         wait_cnt;
  logic [SW-1:0]         starve_cnt;
  logic [DATA_W-1:0]     p_data_q, pd_sel;
  logic                  ack_sel, aux_rd_q;
  logic                  cpu_acc, cpu_mem, force_aux, cpu_mem_go;
  logic                  start, unmapped, ack_hit, timeout;

  mmio_window_decode #(
    .NUM_PERIPH(NUM_PERIPH), .MMIO_UPPER(MMIO_UPPER),
    .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE)
  ) u_dec (
    .addr(cpu_addr), .mmio(mmio), .hit(hit), .idx(idx), .rel_off(rel_off)
  );

  assign any_hit    = |hit;
  assign cpu_acc    = (cpu_wea | cpu_rea) & ~Rst;
  assign cpu_mem    = cpu_acc & ~mmio;
  assign force_aux  = aux_req & (starve_cnt == SW'(STARVE_LIM));
  assign cpu_mem_go = cpu_mem & ~force_aux;
  assign aux_gnt    = aux_req & ~Rst & ~cpu_mem_go;
  assign start      = (state == IDLE) & cpu_acc & any_hit;
  assign unmapped   = (state == IDLE) & cpu_acc & mmio & ~any_hit;

  always_comb begin
    pd_sel  = '0;
    ack_sel = 1'b0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (ch_q == IDX_W'(i)) begin
        pd_sel  = p_dout[i*DATA_W +: DATA_W];
        ack_sel = p_ack[i];
      end
    end
  end

  assign ack_hit = (state == REQ) & ack_sel;
  assign timeout = (state == REQ) & ~ack_sel & (wait_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    cpu_hold  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          cpu_hold  = 1'b1;
        end else if (cpu_mem & force_aux) begin
          cpu_hold = 1'b1;
        end
      end
      REQ: begin
        cpu_hold = 1'b1;
        if (ack_hit || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;  // the still-present request is consumed here
      default: state_nxt = IDLE;
    endcase
  end

  // Aux addresses are already BRAM-relative; only CPU addresses are rebased.
  always_comb begin
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_wen     = 4'h0;
    mem_strctrl = 3'b000;
    mem_addr    = '0;
    mem_din     = '0;
    if (aux_gnt) begin
      mem_req     = 1'b1;
      mem_wr      = aux_wr;
      mem_wen     = aux_wr ? 4'hF : 4'h0;
      mem_strctrl = aux_wr ? 3'b100 : 3'b000;
      mem_addr    = aux_addr;
      mem_din     = aux_din;
    end else if (cpu_mem_go) begin
      mem_req     = 1'b1;
      mem_wr      = cpu_wea;
      mem_wen     = cpu_wea ? cpu_en : 4'h0;
      mem_strctrl = cpu_storecntrl;
      mem_addr    = cpu_addr - MEM_OFFSET;
      mem_din     = cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state      <= IDLE;
      p_req      <= '0;
      p_wr       <= 1'b0;
      p_addr     <= '0;
      p_din      <= '0;
      ch_q       <= '0;
      wait_cnt   <= '0;
      p_data_q   <= '0;
      src_q      <= SRC_ZERO;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      aux_rd_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        p_req    <= NUM_PERIPH'(1) << idx;
        p_wr     <= cpu_wea;
        p_addr   <= rel_off;
        p_din    <= cpu_din;
        ch_q     <= idx;
        wait_cnt <= '0;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (state_nxt == DONE) p_req <= '0;
      end
      if (ack_hit)      p_data_q <= pd_sel;
      else if (timeout) p_data_q <= '0;

      if (cpu_mem_go)                             src_q <= SRC_MEM;
      else if (state == REQ && state_nxt == DONE) src_q <= SRC_PERIPH;
      else                                        src_q <= SRC_ZERO;

      if (timeout | unmapped) bus_err <= 1'b1;
      else if (err_clr)       bus_err <= 1'b0;

      if (aux_gnt)                                     starve_cnt <= '0;
      else if (aux_req && starve_cnt != SW'(STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;
      aux_rd_q <= aux_gnt & ~aux_wr;
    end
  end

  always_comb begin
    unique case (src_q)
      SRC_MEM:    cpu_dout = mem_dout;
      SRC_PERIPH: cpu_dout = p_data_q;
      default:    cpu_dout = '0;
    endcase
  end

  assign aux_dout = aux_rd_q ? mem_dout : '0;
endmodule

// File: tb/tb_mmio_bus_router.sv
// Directed bench for mmio_bus_router: inputs driven 1ns after posedge, outputs sampled 2ns after.
module tb_mmio_bus_router;
  logic         clk = 1'b0, rst = 1'b1;
  logic [31:0]  cpu_addr = '0, cpu_din = '0, cpu_dout;
  logic         cpu_wea = 0, cpu_rea = 0, cpu_hold;
  logic [3:0]   cpu_en = '0;
  logic [2:0]   cpu_storecntrl = '0;
  logic [3:0]   p_req, p_ack = '0;
  logic         p_wr;
  logic [11:0]  p_addr;
  logic [31:0]  p_din;
  logic [127:0] p_dout = {32'h44444444, 32'h33333333, 32'h11112222, 32'h0000005A};
  logic         aux_req = 0, aux_wr = 0, aux_gnt;
  logic [31:0]  aux_addr = '0, aux_din = '0, aux_dout;
  logic         mem_req, mem_wr;
  logic [3:0]   mem_wen;
  logic [2:0]   mem_strctrl;
  logic [31:0]  mem_addr, mem_din, mem_dout = '0;
  logic         bus_err, err_clr = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mmio_bus_router dut (
    .clk(clk), .Rst(rst),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wea(cpu_wea), .cpu_rea(cpu_rea),
    .cpu_en(cpu_en), .cpu_storecntrl(cpu_storecntrl), .cpu_dout(cpu_dout), .cpu_hold(cpu_hold),
    .p_req(p_req), .p_wr(p_wr), .p_addr(p_addr), .p_din(p_din), .p_ack(p_ack), .p_dout(p_dout),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_din(aux_din),
    .aux_gnt(aux_gnt), .aux_dout(aux_dout),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_strctrl(mem_strctrl),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); #1;
    checks++; if (p_req !== 4'h0) begin failures++; $display("FAIL reset_p_req got=%h exp=0", p_req); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", cpu_hold); end
    checks++; if (aux_gnt !== 1'b0) begin failures++; $display("FAIL reset_aux_gnt got=%b exp=0", aux_gnt); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    checks++; if (cpu_dout !== 32'h0) begin failures++; $display("FAIL reset_cpu_dout got=%h exp=0", cpu_dout); end
    tick(); rst = 1'b0;
  endtask

  // ch0 read, ack in the third request cycle; a stray ack on ch1 must be ignored
  task automatic test_periph_read();
    int holds;
    tick(); cpu_addr = 32'hAAAAA404; cpu_rea = 1; #1;
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rd_hold_first got=%b exp=1", cpu_hold); end
    checks++; if (p_req !== 4'h0) begin failures++; $display("FAIL rd_p_req_early got=%h exp=0", p_req); end
    holds = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      p_ack = (k == 1) ? 4'b0010 : (k == 3) ? 4'b0001 : 4'b0000;
      #1;
      if (cpu_hold) holds++;
      if (k == 1) begin
        checks++; if (p_req !== 4'b0001) begin failures++; $display("FAIL rd_p_req got=%h exp=1", p_req); end
        checks++; if (p_addr !== 12'h004) begin failures++; $display("FAIL rd_p_addr got=%h exp=004", p_addr); end
        checks++; if (p_wr !== 1'b0) begin failures++; $display("FAIL rd_p_wr got=%b exp=0", p_wr); end
      end
    end
    tick(); p_ack = 4'h0; #1;
    checks++; if (holds !== 4) begin failures++; $display("FAIL rd_hold_cycles got=%0d exp=4", holds); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL rd_done_hold got=%b exp=0", cpu_hold); end
    checks++; if (p_req !== 4'h0) begin failures++; $display("FAIL rd_done_p_req got=%h exp=0", p_req); end
    checks++; if (cpu_dout !== 32'h5A) begin failures++; $display("FAIL rd_cpu_dout got=%h exp=0000005a", cpu_dout); end
    cpu_rea = 0;
  endtask

  // last byte of ch1 window, immediate ack; aux gets the memory while the CPU waits
  task automatic test_periph_ch1();
    tick(); cpu_addr = 32'hAAAAA501; cpu_rea = 1;
    tick(); p_ack = 4'b0010; aux_req = 1; aux_wr = 0; #1;
    checks++; if (p_req !== 4'b0010) begin failures++; $display("FAIL ch1_p_req got=%h exp=2", p_req); end
    checks++; if (p_addr !== 12'h001) begin failures++; $display("FAIL ch1_p_addr got=%h exp=001", p_addr); end
    checks++; if (aux_gnt !== 1'b1) begin failures++; $display("FAIL ch1_aux_gnt got=%b exp=1", aux_gnt); end
    tick(); p_ack = 4'h0; aux_req = 0; #1;
    checks++; if (cpu_dout !== 32'h11112222) begin failures++; $display("FAIL ch1_cpu_dout got=%h exp=11112222", cpu_dout); end
    cpu_rea = 0;
  endtask

  task automatic test_timeout();
    int holds;
    tick(); cpu_addr = 32'hAAAAA600; cpu_wea = 1; cpu_en = 4'hF; cpu_din = 32'hDEADBEEF; #1;
    holds = cpu_hold ? 1 : 0;
    tick(); #1;
    checks++; if (p_req !== 4'b0100) begin failures++; $display("FAIL to_p_req got=%h exp=4", p_req); end
    checks++; if (p_wr !== 1'b1 || p_addr !== 12'h000 || p_din !== 32'hDEADBEEF) begin
      failures++; $display("FAIL to_p_fields got=%b/%h/%h exp=1/000/deadbeef", p_wr, p_addr, p_din); end
    for (int k = 0; k < 40 && cpu_hold; k++) begin
      holds++; tick(); #1;
    end
    checks++; if (holds !== 17) begin failures++; $display("FAIL to_hold_cycles got=%0d exp=17", holds); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL to_bus_err got=%b exp=1", bus_err); end
    checks++; if (cpu_dout !== 32'h0) begin failures++; $display("FAIL to_cpu_dout got=%h exp=0", cpu_dout); end
    cpu_wea = 0;
    tick(); err_clr = 1; tick(); err_clr = 0; #1;
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_err_clr got=%b exp=0", bus_err); end
  endtask

  // unmapped page offset; err_clr in the same cycle loses to the new error
  task automatic test_unmapped();
    tick(); cpu_addr = 32'hAAAAA900; cpu_rea = 1; err_clr = 1; #1;
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL um_hold got=%b exp=0", cpu_hold); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL um_mem_req got=%b exp=0", mem_req); end
    tick(); cpu_rea = 0; err_clr = 0; mem_dout = 32'h12345678; #1;
    checks++; if (cpu_dout !== 32'h0) begin failures++; $display("FAIL um_cpu_dout got=%h exp=0", cpu_dout); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL um_err_wins got=%b exp=1", bus_err); end
    checks++; if (p_req !== 4'h0) begin failures++; $display("FAIL um_p_req got=%h exp=0", p_req); end
    err_clr = 1; tick(); err_clr = 0;
    cpu_addr = 32'hAAAAA502; cpu_rea = 1; #1;  // one past the end of ch1
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL edge_hold got=%b exp=0", cpu_hold); end
    tick(); cpu_rea = 0; #1;
    checks++; if (bus_err !== 1'b1 || p_req !== 4'h0) begin
      failures++; $display("FAIL edge_err got=%b/%h exp=1/0", bus_err, p_req); end
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic test_mem();
    tick(); cpu_addr = 32'h00002010; cpu_rea = 1; cpu_en = 4'hF; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_wen !== 4'h0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL mem_rd got=%b/%h/%h/%b exp=1/00000010/0/0", mem_req, mem_addr, mem_wen, cpu_hold); end
    tick(); cpu_rea = 0; mem_dout = 32'hCAFEF00D; #1;
    checks++; if (cpu_dout !== 32'hCAFEF00D) begin failures++; $display("FAIL mem_cpu_dout got=%h exp=cafef00d", cpu_dout); end
    cpu_addr = 32'h00001000; cpu_wea = 1; cpu_en = 4'b0011; cpu_storecntrl = 3'b010; cpu_din = 32'h0BADC0DE; #1;
    checks++; if (mem_addr !== 32'hFFFFF000 || mem_wen !== 4'b0011 || mem_wr !== 1'b1) begin
      failures++; $display("FAIL mem_wr got=%h/%h/%b exp=fffff000/3/1", mem_addr, mem_wen, mem_wr); end
    checks++; if (mem_strctrl !== 3'b010 || mem_din !== 32'h0BADC0DE) begin
      failures++; $display("FAIL mem_wr_data got=%b/%h exp=010/0badc0de", mem_strctrl, mem_din); end
    tick(); cpu_wea = 0; cpu_storecntrl = 0;
  endtask

  task automatic test_aux();
    aux_req = 1; aux_wr = 1; aux_addr = 32'h40; aux_din = 32'h77; #1;
    checks++; if (aux_gnt !== 1'b1 || mem_wen !== 4'hF || mem_strctrl !== 3'b100 || mem_din !== 32'h77) begin
      failures++; $display("FAIL aux_wr got=%b/%h/%b/%h exp=1/f/100/00000077", aux_gnt, mem_wen, mem_strctrl, mem_din); end
    tick(); aux_wr = 0; #1;
    checks++; if (aux_gnt !== 1'b1 || mem_wen !== 4'h0 || mem_strctrl !== 3'b000) begin
      failures++; $display("FAIL aux_rd got=%b/%h/%b exp=1/0/000", aux_gnt, mem_wen, mem_strctrl); end
    tick(); aux_req = 0; mem_dout = 32'hA5A50001; #1;
    checks++; if (aux_dout !== 32'hA5A50001) begin failures++; $display("FAIL aux_dout got=%h exp=a5a50001", aux_dout); end
  endtask

  task automatic test_back_to_back();
    int gnt_at = -1, gnts = 0, holds = 0;
    tick(); cpu_addr = 32'h00002010; cpu_rea = 1; aux_req = 1; aux_wr = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (aux_gnt) begin gnts++; if (gnt_at < 0) gnt_at = i; end
      if (cpu_hold) holds++;
      tick();
    end
    cpu_rea = 0; aux_req = 0;
    checks++; if (gnt_at !== 8) begin failures++; $display("FAIL starve_gnt_at got=%0d exp=8", gnt_at); end
    checks++; if (gnts !== 1 || holds !== 1) begin
      failures++; $display("FAIL starve_counts got=%0d/%0d exp=1/1", gnts, holds); end
  endtask

  task automatic test_reset_mid_req();
    tick(); cpu_addr = 32'hAAAAA404; cpu_rea = 1;
    tick(); #1;
    checks++; if (p_req !== 4'b0001) begin failures++; $display("FAIL rmr_pre got=%h exp=1", p_req); end
    rst = 1; cpu_rea = 0; aux_req = 1;
    tick(); #1;
    checks++; if (p_req !== 4'h0 || cpu_hold !== 1'b0 || aux_gnt !== 1'b0) begin
      failures++; $display("FAIL rmr_drop got=%h/%b/%b exp=0/0/0", p_req, cpu_hold, aux_gnt); end
    rst = 0; aux_req = 0; p_ack = 4'b0001;
    tick(); p_ack = 4'h0; #1;
    checks++; if (p_req !== 4'h0 || cpu_hold !== 1'b0 || cpu_dout !== 32'h0) begin
      failures++; $display("FAIL rmr_late_ack got=%h/%b/%h exp=0/0/0", p_req, cpu_hold, cpu_dout); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_periph_read();
    test_periph_ch1();
    test_timeout();
    test_unmapped();
    test_mem();
    test_aux();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
